// File: rtl/bus_arbiter.sv
// Two-master (ibus m0, dbus m1) to one-slave bus arbiter with completion watchdog.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise FIXED_PRIO wins ties.
package bus_arbiter_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_e;
endpackage

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_breq,
  input  logic        m0_bstart,
  input  ttype_e      m0_ttype,
  input  tsize_e      m0_tsize,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_bdone,
  input  logic        m1_breq,
  input  logic        m1_bstart,
  input  ttype_e      m1_ttype,
  input  tsize_e      m1_tsize,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_bdone,
  output logic        s_breq,
  output logic        s_bstart,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_bdone,
  output logic [1:0]  grant,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_e;

  localparam logic [31:0] WD_LAST = 32'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e      state;
  state_e      state_nxt;
  logic [31:0] wd_cnt;
  logic        m0_req;
  logic        m1_req;
  logic        busy;
  logic        wd_hit;
  logic        tie_pick1;

  assign m0_req = m0_breq & m0_bstart;
  assign m1_req = m1_breq & m1_bstart;
  assign busy   = (state == BUSY0) || (state == BUSY1);

  // A real s_bdone in the deadline cycle takes precedence over the forced completion.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && busy && (wd_cnt == WD_LAST) && !s_bdone;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && state_nxt == BUSY0) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && state_nxt == BUSY1) begin
      last_grant <= 1'b1;
    end
  end

  assign tie_pick1 = ~last_grant;
`else
  assign tie_pick1 = (FIXED_PRIO == 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wd_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Held at zero in IDLE so every BUSY entry starts counting from zero.
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant       = 2'b00;
    s_breq      = 1'b0;
    s_bstart    = 1'b0;
    s_ttype     = READ;
    s_tsize     = WORD;
    s_addr      = '0;
    s_wdata     = '0;
    m0_bdone    = 1'b0;
    m1_bdone    = 1'b0;
    m0_rdata    = s_rdata;
    m1_rdata    = s_rdata;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = tie_pick1 ? BUSY1 : BUSY0;
        end else if (m0_req) begin
          state_nxt = BUSY0;
        end else if (m1_req) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0: begin
        grant    = 2'b01;
        s_breq   = 1'b1;
        s_bstart = 1'b1;
        s_ttype  = m0_ttype;
        s_tsize  = m0_tsize;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        if (s_bdone || wd_hit) begin
          m0_bdone  = 1'b1;
          state_nxt = IDLE;
        end
        if (wd_hit) begin
          m0_rdata    = TIMEOUT_RDATA;
          err_timeout = 1'b1;
        end
      end
      BUSY1: begin
        grant    = 2'b10;
        s_breq   = 1'b1;
        s_bstart = 1'b1;
        s_ttype  = m1_ttype;
        s_tsize  = m1_tsize;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        if (s_bdone || wd_hit) begin
          m1_bdone  = 1'b1;
          state_nxt = IDLE;
        end
        if (wd_hit) begin
          m1_rdata    = TIMEOUT_RDATA;
          err_timeout = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed cycle table, timeout/reset sequences, randomized run vs. reference model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int          TO    = 8;
  localparam int          FIXED = 1;
  localparam logic [31:0] TRD   = 32'hDEAD_BEEF;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_breq, m0_bstart, m1_breq, m1_bstart;
  ttype_e      m0_ttype, m1_ttype, s_ttype;
  tsize_e      m0_tsize, m1_tsize, s_tsize;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic        m0_bdone, m1_bdone, s_breq, s_bstart, s_bdone, err_timeout;
  logic [1:0]  grant;

  logic        ma_breq[2];
  logic        ma_bstart[2];
  ttype_e      ma_tt[2];
  tsize_e      ma_ts[2];
  logic [31:0] ma_addr[2];
  logic [31:0] ma_wdata[2];

  int n_vec = 0;
  int n_bad = 0;

  assign m0_breq   = ma_breq[0];
  assign m0_bstart = ma_bstart[0];
  assign m0_ttype  = ma_tt[0];
  assign m0_tsize  = ma_ts[0];
  assign m0_addr   = ma_addr[0];
  assign m0_wdata  = ma_wdata[0];
  assign m1_breq   = ma_breq[1];
  assign m1_bstart = ma_bstart[1];
  assign m1_ttype  = ma_tt[1];
  assign m1_tsize  = ma_ts[1];
  assign m1_addr   = ma_addr[1];
  assign m1_wdata  = ma_wdata[1];

  always #5 clk = ~clk;

  bus_arbiter #(.FIXED_PRIO(FIXED), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone),
    .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone),
    .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .grant(grant), .err_timeout(err_timeout)
  );

  typedef struct {
    bit          rst_n;
    bit          r0;
    bit          r1;
    bit          sd;
    logic [31:0] srd;
    int          own;
    bit          d0;
    bit          d1;
    logic [31:0] rd;
  } row_t;

  row_t tbl[$];
  int   w;
  int   l;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h, want %h", tag, what, act, exp);
    end
  endtask

  // own: -1 idle, else index of the master that should hold the bus this cycle.
  task automatic check_cycle(input string tag, input int own, input bit d0, input bit d1,
                             input bit err, input logic [31:0] rd0, input logic [31:0] rd1);
    logic [1:0]  eg;
    logic [31:0] ett, ets, ea, ewd;
    eg  = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    ett = (own < 0) ? 32'(READ) : 32'(ma_tt[own]);
    ets = (own < 0) ? 32'(WORD) : 32'(ma_ts[own]);
    ea  = (own < 0) ? 32'h0 : ma_addr[own];
    ewd = (own < 0) ? 32'h0 : ma_wdata[own];
    chk(tag, "grant", 32'(grant), 32'(eg));
    chk(tag, "s_breq", 32'(s_breq), 32'(own >= 0));
    chk(tag, "s_bstart", 32'(s_bstart), 32'(own >= 0));
    chk(tag, "s_ttype", 32'(s_ttype), ett);
    chk(tag, "s_tsize", 32'(s_tsize), ets);
    chk(tag, "s_addr", s_addr, ea);
    chk(tag, "s_wdata", s_wdata, ewd);
    chk(tag, "m0_bdone", 32'(m0_bdone), 32'(d0));
    chk(tag, "m1_bdone", 32'(m1_bdone), 32'(d1));
    chk(tag, "m0_rdata", m0_rdata, rd0);
    chk(tag, "m1_rdata", m1_rdata, rd1);
    chk(tag, "err_timeout", 32'(err_timeout), 32'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit r);
    ma_breq[i]   = r;
    ma_bstart[i] = r;
  endtask

  task automatic add(input bit rs, input bit r0, input bit r1, input bit sd,
                     input logic [31:0] srd, input int own, input logic [31:0] rd);
    row_t v;
    v.rst_n = rs; v.r0 = r0; v.r1 = r1; v.sd = sd; v.srd = srd; v.own = own;
    v.d0 = sd && (own == 0);
    v.d1 = sd && (own == 1);
    v.rd = rd;
    tbl.push_back(v);
  endtask

  // Rows phrased by first winner w / other master l of a simultaneous request after reset.
  task automatic addp(input bit rs, input bit rw, input bit rl, input bit sd,
                      input logic [31:0] srd, input int own, input logic [31:0] rd);
    add(rs, (w == 0) ? rw : rl, (w == 0) ? rl : rw, sd, srd, own, rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int own, age, last;
    bit pend[2];
    bit drop[2];
    bit to, fin;

    w = RR ? 0 : FIXED;
    l = 1 - w;

    rst_n = 1'b0; s_bdone = 1'b0; s_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0);
    end
    ma_tt[0] = READ;  ma_ts[0] = WORD; ma_addr[0] = 32'h0000_0010; ma_wdata[0] = 32'h0;
    ma_tt[1] = WRITE; ma_ts[1] = BYTE; ma_addr[1] = 32'h2000_0003; ma_wdata[1] = 32'h0000_00AB;

    repeat (3) tick();
    @(negedge clk);
    check_cycle("reset", -1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    add(1, 1, 0, 0, 32'h0,         -1, 32'h0);
    add(1, 1, 0, 0, 32'h0,          0, 32'h0);
    add(1, 1, 0, 0, 32'h0,          0, 32'h0);
    add(1, 1, 0, 0, 32'h0,          0, 32'h0);
    add(1, 1, 0, 1, 32'h1234_5678,  0, 32'h1234_5678);
    add(1, 0, 0, 0, 32'h0,         -1, 32'h0);
    add(1, 1, 1, 0, 32'h0,         -1, 32'h0);
    add(1, 1, 1, 0, 32'h0,          1, 32'h0);
    add(1, 1, 1, 1, 32'hAAAA_0001,  1, 32'hAAAA_0001);
    add(1, 1, 0, 0, 32'h0,         -1, 32'h0);
    add(1, 1, 0, 1, 32'hBBBB_0002,  0, 32'hBBBB_0002);
    add(1, 0, 0, 0, 32'h0,         -1, 32'h0);
    add(0, 0, 0, 0, 32'h0,         -1, 32'h0);
    addp(1, 1, 1, 0, 32'h0,         -1, 32'h0);
    addp(1, 1, 1, 1, 32'hC000_0001,  w, 32'hC000_0001);
    addp(1, 0, 1, 0, 32'h0,         -1, 32'h0);
    addp(1, 1, 1, 1, 32'hC000_0002,  l, 32'hC000_0002);
    addp(1, 1, 0, 0, 32'h0,         -1, 32'h0);
    addp(1, 1, 1, 1, 32'hC000_0003,  w, 32'hC000_0003);
    addp(1, 0, 1, 0, 32'h0,         -1, 32'h0);
    addp(1, 1, 1, 1, 32'hC000_0004,  l, 32'hC000_0004);
    addp(1, 0, 0, 0, 32'h0,         -1, 32'h0);

    foreach (tbl[i]) begin
      rst_n   = tbl[i].rst_n;
      set_req(0, tbl[i].r0);
      set_req(1, tbl[i].r1);
      s_bdone = tbl[i].sd;
      s_rdata = tbl[i].srd;
      @(negedge clk);
      check_cycle($sformatf("row%0d", i), tbl[i].own, tbl[i].d0, tbl[i].d1, 1'b0,
                  tbl[i].d0 ? tbl[i].rd : tbl[i].srd, tbl[i].d1 ? tbl[i].rd : tbl[i].srd);
      tick();
    end

    // Watchdog: dead slave, then s_bdone arriving exactly in the deadline cycle.
    for (int pass = 0; pass < 2; pass++) begin
      set_req(0, 1'b1);
      s_bdone = 1'b0;
      s_rdata = 32'h0;
      @(negedge clk);
      check_cycle("to_idle", -1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      for (int k = 1; k <= TO; k++) begin
        s_bdone = (pass == 1) && (k == TO);
        s_rdata = 32'h5A5A_0000 + 32'(k);
        @(negedge clk);
        if (k < TO) begin
          check_cycle($sformatf("to%0d_c%0d", pass, k), 0, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
        end else if (pass == 0) begin
          check_cycle("to_fire", 0, 1'b1, 1'b0, 1'b1, TRD, 32'h5A5A_0008);
        end else begin
          check_cycle("to_race", 0, 1'b1, 1'b0, 1'b0, 32'h5A5A_0008, 32'h5A5A_0008);
        end
        tick();
      end
      set_req(0, 1'b0);
      s_bdone = 1'b0;
      @(negedge clk);
      check_cycle("to_after", -1, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
      tick();
    end

    // Reset while m1 owns the slave, then a fresh m0 request.
    set_req(1, 1'b1);
    tick();
    @(negedge clk);
    check_cycle("rst_busy1", 1, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_cycle("rst_hit", -1, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
    tick();
    rst_n = 1'b1;
    set_req(1, 1'b0);
    set_req(0, 1'b1);
    @(negedge clk);
    check_cycle("rst_rel", -1, 1'b0, 1'b0, 1'b0, s_rdata, s_rdata);
    tick();
    s_bdone = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check_cycle("rst_m0", 0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D);
    tick();
    set_req(0, 1'b0);
    s_bdone = 1'b0;

    // Randomized traffic against a transaction-level reference.
    rst_n = 1'b0;
    tick();
    own = -1; age = 0; last = 1;
    pend[0] = 0; pend[1] = 0; drop[0] = 0; drop[1] = 0;
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin
          drop[i] = 0; pend[i] = 0; set_req(i, 1'b0);
        end else if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i]     = 1;
            set_req(i, 1'b1);
            ma_tt[i]    = ttype_e'($urandom_range(0, 1));
            ma_ts[i]    = tsize_e'($urandom_range(0, 2));
            ma_addr[i]  = $urandom;
            ma_wdata[i] = $urandom;
          end else begin
            case ($urandom_range(0, 2))
              0:       begin ma_breq[i] = 1'b1; ma_bstart[i] = 1'b0; end
              1:       begin ma_breq[i] = 1'b0; ma_bstart[i] = 1'b1; end
              default: set_req(i, 1'b0);
            endcase
          end
        end else if (own != i && $urandom_range(0, 15) == 0) begin
          pend[i] = 0; set_req(i, 1'b0);
        end
      end
      s_bdone = (own >= 0) && ($urandom_range(0, 5) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      to  = (own >= 0) && (age == TO - 1) && !s_bdone;
      fin = (own >= 0) && (s_bdone || to);
      check_cycle($sformatf("rand%0d", c), own, fin && own == 0, fin && own == 1, to,
                  (to && own == 0) ? TRD : s_rdata, (to && own == 1) ? TRD : s_rdata);
      if (fin) drop[own] = 1;
      if (!rst_n) begin
        own = -1; age = 0; last = 1;
      end else if (own < 0) begin
        if (ma_breq[0] && ma_bstart[0] && ma_breq[1] && ma_bstart[1]) own = RR ? (1 - last) : FIXED;
        else if (ma_breq[0] && ma_bstart[0]) own = 0;
        else if (ma_breq[1] && ma_bstart[1]) own = 1;
        if (own >= 0) begin
          age = 0; last = own;
        end
      end else if (fin) begin
        own = -1;
      end else begin
        age++;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
